// File: rtl/fmul_dispatch.sv
// Issue stage for the fmul unit: request FIFO, single-op dispatch FSM with a
// watchdog on the multiplier, and a valid/ready result port toward writeback.
module fmul_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      mul_x1,
    output logic [31:0]      mul_x2,
    output logic             mul_ready,
    input  logic             mul_valid,
    input  logic [31:0]      mul_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_y,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy,
    output logic             err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam int unsigned EW = 64 + TAG_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [31:0]      op_x1_q, op_x1_d;
    logic [31:0]      op_x2_q, op_x2_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;
    logic [31:0]      res_y_q, res_y_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             err_q, err_d;
    logic             push, pop;

    // Readiness comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign req_ready = !rst && (count_q != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        op_x1_d   = op_x1_q;
        op_x2_d   = op_x2_q;
        op_tag_d  = op_tag_q;
        res_y_d   = res_y_q;
        res_tag_d = res_tag_q;
        wdog_d    = wdog_q;
        err_d     = err_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {op_x1_d, op_x2_d, op_tag_d} = mem_q[rd_ptr_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_valid) begin
                    res_y_d   = mul_y;
                    res_tag_d = op_tag_q;
                    state_d   = S_DONE;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    // Hung multiplier: return a quiet NaN so writeback still retires the tag.
                    res_y_d   = 32'h7fc0_0000;
                    res_tag_d = op_tag_q;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: begin
                if (res_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_x1, req_x2, req_tag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            op_x1_q   <= '0;
            op_x2_q   <= '0;
            op_tag_q  <= '0;
            res_y_q   <= '0;
            res_tag_q <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            op_x1_q   <= op_x1_d;
            op_x2_q   <= op_x2_d;
            op_tag_q  <= op_tag_d;
            res_y_q   <= res_y_d;
            res_tag_q <= res_tag_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
        end
    end

    assign mul_x1    = op_x1_q;
    assign mul_x2    = op_x2_q;
    assign mul_ready = (state_q == S_ISSUE);
    assign res_valid = (state_q == S_DONE);
    assign res_y     = res_y_q;
    assign res_tag   = res_tag_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign err       = err_q;
endmodule
